// File: rtl/tl_inflight_monitor_if.sv
`default_nettype none
// ============================================================================
// Module   : tl_inflight_monitor_if
// Purpose  : TileLink-UH channel A / channel D signal bundle.
//            master  - requester side (drives A, accepts D)
//            slave   - responder side (accepts A, drives D)
//            monitor - passive observer, every signal is an input
// Signals  : a_valid/a_ready/a_opcode/a_size/a_source/a_address/a_mask
//            d_valid/d_ready/d_opcode/d_size/d_source
// Revision : 1.0 - initial release
// ============================================================================
interface tl_inflight_monitor_if #(
  parameter int SOURCE_BITS = 9,
  parameter int ADDR_BITS   = 32,
  parameter int SIZE_BITS   = 3,
  parameter int DATA_BYTES  = 8
);
  logic                   a_valid;
  logic                   a_ready;
  logic [2:0]             a_opcode;
  logic [SIZE_BITS-1:0]   a_size;
  logic [SOURCE_BITS-1:0] a_source;
  logic [ADDR_BITS-1:0]   a_address;
  logic [DATA_BYTES-1:0]  a_mask;

  logic                   d_valid;
  logic                   d_ready;
  logic [2:0]             d_opcode;
  logic [SIZE_BITS-1:0]   d_size;
  logic [SOURCE_BITS-1:0] d_source;

  modport master (
    output a_valid, a_opcode, a_size, a_source, a_address, a_mask, d_ready,
    input  a_ready, d_valid, d_opcode, d_size, d_source
  );

  modport slave (
    input  a_valid, a_opcode, a_size, a_source, a_address, a_mask, d_ready,
    output a_ready, d_valid, d_opcode, d_size, d_source
  );

  modport monitor (
    input a_valid, a_ready, a_opcode, a_size, a_source, a_address, a_mask,
    input d_valid, d_ready, d_opcode, d_size, d_source
  );
endinterface
`default_nettype wire

// File: rtl/tl_inflight_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tl_inflight_monitor
// Purpose  : Passive TileLink-UH monitor. Tracks one outstanding request per
//            source between channel A and channel D and flags protocol
//            violations (A alignment/opcode/burst stability, D correlation,
//            D size/opcode match, response timeout).
// Ports    : clock, reset_n (async, active low)
//            enable       - 0 freezes all tracking state, no errors raised
//            clear_errors - clears err_sticky on the next edge
//            tl           - monitor view of the A/D channels
//            err_pulse    - one-cycle pulse, cycle after offending fire
//            err_code     - lowest code of the last reported error cycle
//            err_sticky   - bit n-1 set by error code n
//            inflight_cnt - number of sources outstanding
// Revision : 1.0 - initial release
// ============================================================================
module tl_inflight_monitor #(
  parameter int SOURCE_BITS = 9,
  parameter int ADDR_BITS   = 32,
  parameter int SIZE_BITS   = 3,
  parameter int DATA_BYTES  = 8,
  parameter int TIMEOUT     = 1024
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   clear_errors,
  tl_inflight_monitor_if.monitor tl,
  output logic                   err_pulse,
  output logic [3:0]             err_code,
  output logic [7:0]             err_sticky,
  output logic [SOURCE_BITS:0]   inflight_cnt
);

  localparam int c_lgb      = $clog2(DATA_BYTES);
  localparam int c_max_size = (1 << SIZE_BITS) - 1;
  // Counter must hold the beat count of the largest burst, 2**(max-lgb).
  localparam int c_beat_w   = (c_max_size > c_lgb) ? (c_max_size - c_lgb + 1) : 1;
  localparam int c_nsrc     = 1 << SOURCE_BITS;
  localparam int c_timer_w  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [c_timer_w-1:0] c_timer_max  = c_timer_w'(TIMEOUT);
  localparam logic [c_timer_w-1:0] c_timer_last = c_timer_w'(TIMEOUT - 1);

  function automatic logic [c_beat_w-1:0] beats_of(input logic burst,
                                                    input logic [SIZE_BITS-1:0] size);
    logic [c_beat_w-1:0] b;
    b = c_beat_w'(1);
    if (burst && (int'(size) > c_lgb))
      b = b << (int'(size) - c_lgb);
    return b;
  endfunction

  // Tracking table
  logic [c_nsrc-1:0]      r_busy;
  logic [SIZE_BITS-1:0]   r_exp_size [c_nsrc];
  logic [1:0]             r_exp_op   [c_nsrc];

  // Channel A burst tracking and captured first-beat fields
  logic [c_beat_w-1:0]    r_a_cnt;
  logic [c_beat_w-1:0]    r_a_total;
  logic [2:0]             r_cap_op;
  logic [SIZE_BITS-1:0]   r_cap_size;
  logic [SOURCE_BITS-1:0] r_cap_src;
  logic [ADDR_BITS-1:0]   r_cap_addr;

  // Channel D burst tracking
  logic [c_beat_w-1:0]    r_d_cnt;
  logic [c_beat_w-1:0]    r_d_total;

  logic [c_timer_w-1:0]   r_timer;

  logic                   w_fire_a;
  logic                   w_fire_d;
  logic                   w_a_first;
  logic                   w_a_last;
  logic [c_beat_w-1:0]    w_a_total;
  logic                   w_d_first;
  logic                   w_d_last;
  logic [c_beat_w-1:0]    w_d_total;
  logic                   w_d_busy;
  logic                   w_retire;
  logic                   w_a_busy_eff;
  logic                   w_alloc;
  logic                   w_alloc_new;
  logic                   w_misalign;
  logic                   w_unstable;
  logic                   w_timer_clr;
  logic                   w_timeout;
  logic [1:0]             w_a_exp_op;
  logic [7:0]             w_err;
  logic [3:0]             w_code;
  logic                   w_unused;

  assign w_unused  = ^tl.a_mask;

  assign w_fire_a  = enable & tl.a_valid & tl.a_ready;
  assign w_fire_d  = enable & tl.d_valid & tl.d_ready;

  // Burst length is fixed by the first beat and held for the rest.
  assign w_a_first = (r_a_cnt == '0);
  assign w_a_total = w_a_first ? beats_of(tl.a_opcode <= 3'd3, tl.a_size) : r_a_total;
  assign w_a_last  = ((r_a_cnt + c_beat_w'(1)) == w_a_total);

  assign w_d_first = (r_d_cnt == '0);
  assign w_d_total = w_d_first ? beats_of(tl.d_opcode == 3'd1, tl.d_size) : r_d_total;
  assign w_d_last  = ((r_d_cnt + c_beat_w'(1)) == w_d_total);

  // D sees the table as it was at the start of the cycle; A sees it after
  // this cycle's retire so a same-cycle retire+allocate is legal.
  assign w_d_busy     = r_busy[tl.d_source];
  assign w_retire     = w_fire_d & w_d_last & w_d_busy;
  assign w_a_busy_eff = r_busy[tl.a_source] & ~(w_retire & (tl.d_source == tl.a_source));
  assign w_alloc      = w_fire_a & w_a_first;
  assign w_alloc_new  = w_alloc & ~w_a_busy_eff;

  assign w_misalign = |(tl.a_address & ~({ADDR_BITS{1'b1}} << tl.a_size));
  assign w_unstable = (tl.a_opcode  != r_cap_op)   | (tl.a_size    != r_cap_size) |
                      (tl.a_source  != r_cap_src)  | (tl.a_address != r_cap_addr);

  assign w_timer_clr = w_fire_d | (inflight_cnt == '0);
  assign w_timeout   = enable & (TIMEOUT != 0) & ~w_timer_clr & (r_timer == c_timer_last);

  always_comb begin
    w_a_exp_op = 2'd0;
    case (tl.a_opcode)
      3'd2, 3'd3, 3'd4: w_a_exp_op = 2'd1;
      3'd5:             w_a_exp_op = 2'd2;
      default:          w_a_exp_op = 2'd0;
    endcase
  end

  assign w_err = {
    w_timeout,
    w_fire_d & w_d_first & w_d_busy & (tl.d_opcode != {1'b0, r_exp_op[tl.d_source]}),
    w_fire_d & w_d_first & w_d_busy & (tl.d_size != r_exp_size[tl.d_source]),
    w_fire_d & ~w_d_busy,
    w_fire_a & ~w_a_first & w_unstable,
    w_alloc & (tl.a_opcode > 3'd5),
    w_alloc & w_a_busy_eff,
    w_alloc & w_misalign
  };

  // Lowest set code wins when several errors coincide.
  always_comb begin
    w_code = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (w_err[i]) w_code = 4'(i + 1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_pulse    <= 1'b0;
      err_code     <= 4'd0;
      err_sticky   <= 8'h00;
      inflight_cnt <= '0;
      r_busy       <= '0;
      r_a_cnt      <= '0;
      r_a_total    <= '0;
      r_cap_op     <= '0;
      r_cap_size   <= '0;
      r_cap_src    <= '0;
      r_cap_addr   <= '0;
      r_d_cnt      <= '0;
      r_d_total    <= '0;
      r_timer      <= '0;
    end else begin
      err_pulse  <= |w_err;
      if (|w_err) err_code <= w_code;
      err_sticky <= (clear_errors ? 8'h00 : err_sticky) | w_err;

      if (w_fire_a) begin
        r_a_cnt <= w_a_last ? '0 : r_a_cnt + c_beat_w'(1);
        if (w_a_first) begin
          r_a_total  <= w_a_total;
          r_cap_op   <= tl.a_opcode;
          r_cap_size <= tl.a_size;
          r_cap_src  <= tl.a_source;
          r_cap_addr <= tl.a_address;
        end
      end

      if (w_fire_d) begin
        r_d_cnt <= w_d_last ? '0 : r_d_cnt + c_beat_w'(1);
        if (w_d_first) r_d_total <= w_d_total;
      end

      // Allocate is written after retire so it wins on the same source.
      if (w_retire) r_busy[tl.d_source] <= 1'b0;
      if (w_alloc)  r_busy[tl.a_source] <= 1'b1;

      inflight_cnt <= inflight_cnt + {{SOURCE_BITS{1'b0}}, w_alloc_new}
                                   - {{SOURCE_BITS{1'b0}}, w_retire};

      if (enable) begin
        if (w_timer_clr)
          r_timer <= '0;
        else if (r_timer != c_timer_max)
          r_timer <= r_timer + c_timer_w'(1);
      end
    end
  end

  // Entry payload needs no reset: it is only consulted while busy is set.
  always_ff @(posedge clock) begin
    if (w_alloc) begin
      r_exp_size[tl.a_source] <= tl.a_size;
      r_exp_op[tl.a_source]   <= w_a_exp_op;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tl_inflight_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_tl_inflight_monitor
// Purpose  : Self-checking bench for tl_inflight_monitor. Directed scenarios
//            followed by randomized traffic, all checked against a
//            behavioural reference model of the monitor rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tl_inflight_monitor;

  localparam int SB = 9;
  localparam int LGB = 3;
  localparam int TIMEOUT = 1024;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b1;
  logic clear_errors = 1'b0;
  logic err_pulse;
  logic [3:0] err_code;
  logic [7:0] err_sticky;
  logic [SB:0] inflight_cnt;

  always #5 clock = ~clock;

  tl_inflight_monitor_if #(.SOURCE_BITS(SB), .ADDR_BITS(32), .SIZE_BITS(3), .DATA_BYTES(8)) bus ();

  tl_inflight_monitor #(
    .SOURCE_BITS(SB), .ADDR_BITS(32), .SIZE_BITS(3), .DATA_BYTES(8), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .clear_errors(clear_errors),
    .tl(bus), .err_pulse(err_pulse), .err_code(err_code), .err_sticky(err_sticky),
    .inflight_cnt(inflight_cnt)
  );

  int total = 0;
  int bad = 0;

  // Reference model state
  bit m_busy [512];
  int m_size [512];
  int m_op   [512];
  int m_a_left, m_d_left, m_idle;
  int cap_op, cap_size, cap_src;
  logic [31:0] cap_addr;
  bit m_pulse;
  int m_code;
  bit [7:0] m_sticky;
  int m_inflight;
  int last_d_src, last_d_op, last_d_size;

  function automatic int nbeats(input int size);
    return (size > LGB) ? (1 << (size - LGB)) : 1;
  endfunction

  function automatic int popcount();
    int n = 0;
    foreach (m_busy[i]) if (m_busy[i]) n++;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_a_left = 0; m_d_left = 0; m_idle = 0;
    m_pulse = 0; m_code = 0; m_sticky = 8'h00; m_inflight = 0;
  endtask

  // Computes the expected outputs after the coming clock edge from the
  // inputs currently driven.
  task automatic model_cycle();
    bit [7:0] e;
    int ds, as_, outstanding, op, sz;
    bit first, fd;
    logic [31:0] addr;
    e = 8'h00;
    outstanding = popcount();
    fd = bus.d_valid && bus.d_ready;
    if (enable) begin
      if (fd) begin
        ds = int'(bus.d_source);
        first = (m_d_left == 0);
        if (first) m_d_left = (bus.d_opcode == 3'd1) ? nbeats(int'(bus.d_size)) : 1;
        if (!m_busy[ds]) e[4] = 1'b1;
        else if (first) begin
          if (int'(bus.d_size) != m_size[ds]) e[5] = 1'b1;
          if (int'(bus.d_opcode) != m_op[ds]) e[6] = 1'b1;
        end
        m_d_left--;
        if (m_d_left == 0) m_busy[ds] = 1'b0;
      end
      if (bus.a_valid && bus.a_ready) begin
        as_ = int'(bus.a_source); op = int'(bus.a_opcode); sz = int'(bus.a_size);
        addr = bus.a_address;
        if (m_a_left == 0) begin
          if ((addr & ((32'd1 << sz) - 32'd1)) != 0) e[0] = 1'b1;
          if (m_busy[as_]) e[1] = 1'b1;
          if (op > 5) e[2] = 1'b1;
          m_busy[as_] = 1'b1;
          m_size[as_] = sz;
          m_op[as_] = (op <= 1) ? 0 : (op <= 4) ? 1 : (op == 5) ? 2 : 0;
          cap_op = op; cap_size = sz; cap_src = as_; cap_addr = addr;
          m_a_left = (op <= 3) ? nbeats(sz) : 1;
        end else if (op != cap_op || sz != cap_size || as_ != cap_src || addr != cap_addr) begin
          e[3] = 1'b1;
        end
        m_a_left--;
      end
      if (fd || outstanding == 0) m_idle = 0;
      else if (m_idle < TIMEOUT) begin
        m_idle++;
        if (m_idle == TIMEOUT) e[7] = 1'b1;
      end
    end
    m_pulse = |e;
    if (|e) for (int i = 7; i >= 0; i--) if (e[i]) m_code = i + 1;
    m_sticky = (clear_errors ? 8'h00 : m_sticky) | e;
    m_inflight = popcount();
  endtask

  task automatic cycle();
    model_cycle();
    @(posedge clock); #1;
    chk("err_pulse", 32'(err_pulse), 32'(m_pulse));
    chk("err_code", 32'(err_code), 32'(m_code));
    chk("err_sticky", 32'(err_sticky), 32'(m_sticky));
    chk("inflight_cnt", 32'(inflight_cnt), 32'(m_inflight));
  endtask

  task automatic drive_a(input int op, input int size, input int src, input logic [31:0] addr);
    bus.a_valid = 1'b1; bus.a_ready = 1'b1;
    bus.a_opcode = 3'(op); bus.a_size = 3'(size); bus.a_source = SB'(src);
    bus.a_address = addr; bus.a_mask = 8'hFF;
  endtask

  task automatic drive_d(input int op, input int size, input int src);
    bus.d_valid = 1'b1; bus.d_ready = 1'b1;
    bus.d_opcode = 3'(op); bus.d_size = 3'(size); bus.d_source = SB'(src);
  endtask

  task automatic idle();
    bus.a_valid = 1'b0; bus.d_valid = 1'b0;
  endtask

  task automatic random_cycle();
    int src, op, sz;
    logic [31:0] addr;
    enable = ($urandom_range(0, 99) >= 5);
    clear_errors = ($urandom_range(0, 99) < 5);
    bus.a_ready = ($urandom_range(0, 99) < 80);
    bus.d_ready = ($urandom_range(0, 99) < 80);
    bus.a_mask = 8'($urandom);
    bus.a_valid = ($urandom_range(0, 99) < 45);
    if (m_a_left > 0 && $urandom_range(0, 9) < 9) begin
      op = cap_op; sz = cap_size; src = cap_src; addr = cap_addr;
    end else begin
      op = ($urandom_range(0, 99) < 5) ? $urandom_range(6, 7) : $urandom_range(0, 5);
      sz = $urandom_range(0, 6);
      src = $urandom_range(0, 15);
      addr = ($urandom & 32'hFFF) & ~((32'd1 << sz) - 32'd1);
      if (sz > 0 && $urandom_range(0, 9) == 0) addr = addr + 32'd1;
    end
    bus.a_opcode = 3'(op); bus.a_size = 3'(sz); bus.a_source = SB'(src); bus.a_address = addr;
    bus.d_valid = ($urandom_range(0, 99) < 40);
    if (m_d_left == 0) begin
      src = $urandom_range(0, 15);
      if ($urandom_range(0, 9) < 7)
        for (int k = 0; k < 16; k++) if (m_busy[(src + k) % 16]) begin src = (src + k) % 16; break; end
      last_d_src = src;
      last_d_op = (m_busy[src] && $urandom_range(0, 9) < 8) ? m_op[src] : $urandom_range(0, 2);
      last_d_size = (m_busy[src] && $urandom_range(0, 9) < 8) ? m_size[src] : $urandom_range(0, 6);
    end
    bus.d_opcode = 3'(last_d_op); bus.d_size = 3'(last_d_size); bus.d_source = SB'(last_d_src);
    cycle();
  endtask

  int pulses, at_cycle;
  int cnt_before;

  initial begin
    bus.a_valid = 1'b0; bus.a_ready = 1'b1; bus.a_opcode = '0; bus.a_size = '0;
    bus.a_source = '0; bus.a_address = '0; bus.a_mask = '0;
    bus.d_valid = 1'b0; bus.d_ready = 1'b1; bus.d_opcode = '0; bus.d_size = '0; bus.d_source = '0;
    last_d_src = 0; last_d_op = 0; last_d_size = 0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_pulse", 32'(err_pulse), 32'd0);
    chk("rst_code", 32'(err_code), 32'd0);
    chk("rst_sticky", 32'(err_sticky), 32'd0);
    chk("rst_inflight", 32'(inflight_cnt), 32'd0);
    reset_n = 1'b1;

    // Get / AccessAckData round trip
    drive_a(4, 2, 3, 32'h100); cycle();
    chk("t1_inflight_up", 32'(inflight_cnt), 32'd1);
    idle(); drive_d(1, 2, 3); cycle();
    chk("t1_inflight_down", 32'(inflight_cnt), 32'd0);
    chk("t1_no_err", 32'(err_pulse), 32'd0);

    // 4-beat PutFull with address change on beat 3
    idle(); drive_a(0, 5, 5, 32'h200); cycle(); cycle();
    drive_a(0, 5, 5, 32'h220); cycle();
    chk("t2_pulse", 32'(err_pulse), 32'd1);
    chk("t2_code", 32'(err_code), 32'd4);
    chk("t2_sticky", 32'(err_sticky), 32'h08);
    drive_a(0, 5, 5, 32'h200); cycle();
    idle(); drive_d(0, 5, 5); cycle();

    // D with nothing outstanding
    idle(); drive_d(0, 0, 7); cycle();
    chk("t3_code", 32'(err_code), 32'd5);

    idle(); clear_errors = 1'b1; cycle(); clear_errors = 1'b0;
    chk("t3_cleared", 32'(err_sticky), 32'd0);

    // Misaligned Get then re-use of the busy source
    drive_a(4, 2, 1, 32'h102); cycle();
    chk("t4_align", 32'(err_code), 32'd1);
    drive_a(4, 2, 1, 32'h104); cycle();
    chk("t4_busy", 32'(err_code), 32'd2);
    chk("t4_sticky", 32'(err_sticky), 32'h03);
    idle(); drive_d(1, 2, 1); cycle();
    idle(); clear_errors = 1'b1; cycle(); clear_errors = 1'b0;

    // Response timeout
    drive_a(4, 0, 2, 32'h0); cycle(); idle();
    pulses = 0; at_cycle = 0;
    for (int k = 1; k <= 1100; k++) begin
      cycle();
      if (err_pulse) begin pulses++; at_cycle = k; end
    end
    chk("t5_pulses", 32'(pulses), 32'd1);
    chk("t5_at", 32'(at_cycle), 32'd1024);
    chk("t5_code", 32'(err_code), 32'd8);
    drive_d(1, 0, 2); cycle(); idle();
    clear_errors = 1'b1; cycle(); clear_errors = 1'b0;

    // Same-cycle retire and allocate on one source
    drive_a(4, 2, 4, 32'h40); cycle();
    cnt_before = int'(inflight_cnt);
    drive_d(1, 2, 4); cycle();
    chk("t6_no_err", 32'(err_pulse), 32'd0);
    chk("t6_inflight", 32'(inflight_cnt), 32'(cnt_before));
    idle(); drive_d(1, 2, 4); cycle(); idle();

    // Disabled monitor ignores traffic
    enable = 1'b0; drive_a(4, 2, 9, 32'h1); cycle(); cycle();
    chk("t7_frozen", 32'(inflight_cnt), 32'd0);
    idle(); enable = 1'b1; cycle();

    // Reset in the middle of a 4-beat burst
    drive_a(0, 5, 6, 32'h300); cycle(); cycle();
    reset_n = 1'b0; #2;
    chk("t8_pulse", 32'(err_pulse), 32'd0);
    chk("t8_code", 32'(err_code), 32'd0);
    chk("t8_sticky", 32'(err_sticky), 32'd0);
    chk("t8_inflight", 32'(inflight_cnt), 32'd0);
    model_reset();
    #2 reset_n = 1'b1;
    drive_a(0, 3, 6, 32'h308); cycle();
    chk("t8_first_beat", 32'(err_pulse), 32'd0);
    chk("t8_alloc", 32'(inflight_cnt), 32'd1);
    idle(); drive_d(0, 3, 6); cycle(); idle();

    // Randomized traffic
    for (int n = 0; n < 4000; n++) random_cycle();
    idle(); enable = 1'b1; clear_errors = 1'b0;
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
